// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencing FSM for a WIDTH-slice restoring divider array
// Optional signed-overflow trap enabled by defining DIVCTRL_OVERFLOW_EN.
module divider_control #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Signed_Mode,
    input  logic Sign_Op1,
    input  logic Sign_Op2,
    input  logic Div_Zero,
    input  logic Trial_Cout,
`ifdef DIVCTRL_OVERFLOW_EN
    input  logic Dividend_Is_Min,
    input  logic Divisor_Is_Minus1,
`endif
    output logic LOAD_DIVL,
    output logic LOAD_DIVH,
    output logic LOAD_ACC,
    output logic STORE_ACC,
    output logic INV_OP1,
    output logic INV_OP2,
    output logic INV_RESULT,
    output logic INV_REM,
    output logic OP1_INV_Cin,
    output logic OP2_INV_Cin,
    output logic RESULT_INV_Cin,
    output logic ACC_INV_Cin,
    output logic ACC_Cin,
    output logic RESULT_nP_0,
    output logic STORE_QUOT,
    output logic STORE_REM,
    output logic Busy,
    output logic Done,
    output logic Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIAL,
        S_COMMIT,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             neg_a;
    logic             neg_b;
    logic             qbit;
    logic             abort;

`ifdef DIVCTRL_OVERFLOW_EN
    assign abort = Div_Zero | (Signed_Mode & Dividend_Is_Min & Divisor_Is_Minus1);
`else
    assign abort = Div_Zero;
`endif

    // Signs are captured on the accepting edge so LOAD's negator selects decode from flops only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            count <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            qbit  <= 1'b0;
            Error <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        neg_a <= Signed_Mode & Sign_Op1;
                        neg_b <= Signed_Mode & Sign_Op2;
                        Error <= 1'b0;
                    end
                end
                S_LOAD: begin
                    count <= '0;
                    if (abort) begin
                        Error <= 1'b1;
                    end
                end
                S_TRIAL: qbit <= Trial_Cout;
                S_COMMIT: begin
                    if (count != LAST) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state     = state;
        LOAD_DIVL      = 1'b0;
        LOAD_DIVH      = 1'b0;
        LOAD_ACC       = 1'b0;
        STORE_ACC      = 1'b0;
        INV_OP1        = 1'b0;
        INV_OP2        = 1'b0;
        INV_RESULT     = 1'b0;
        INV_REM        = 1'b0;
        OP1_INV_Cin    = 1'b0;
        OP2_INV_Cin    = 1'b0;
        RESULT_INV_Cin = 1'b0;
        ACC_INV_Cin    = 1'b0;
        ACC_Cin        = 1'b0;
        RESULT_nP_0    = 1'b0;
        STORE_QUOT     = 1'b0;
        STORE_REM      = 1'b0;
        Busy           = 1'b0;
        Done           = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                LOAD_DIVL   = 1'b1;
                LOAD_DIVH   = 1'b1;
                LOAD_ACC    = 1'b1;
                STORE_ACC   = 1'b1;
                INV_OP1     = neg_a;
                OP1_INV_Cin = neg_a;
                INV_OP2     = neg_b;
                OP2_INV_Cin = neg_b;
                Busy        = 1'b1;
                next_state  = abort ? S_DONE : S_TRIAL;
            end
            S_TRIAL: begin
                ACC_Cin    = 1'b1;
                Busy       = 1'b1;
                next_state = S_COMMIT;
            end
            // A failed trial leaves ACC untouched, which is the restore.
            S_COMMIT: begin
                STORE_ACC   = qbit;
                RESULT_nP_0 = ~qbit;
                Busy        = 1'b1;
                next_state  = (count == LAST) ? S_STORE : S_TRIAL;
            end
            S_STORE: begin
                STORE_QUOT     = 1'b1;
                STORE_REM      = 1'b1;
                INV_RESULT     = neg_a ^ neg_b;
                RESULT_INV_Cin = neg_a ^ neg_b;
                INV_REM        = neg_a;
                ACC_INV_Cin    = neg_a;
                Busy           = 1'b1;
                next_state     = S_DONE;
            end
            S_DONE: begin
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_divider_control.sv
// tb/tb_divider_control.sv - scoreboard bench for divider_control
`timescale 1ns/1ps
module tb_divider_control;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic Signed_Mode = 1'b0;
    logic Sign_Op1 = 1'b0;
    logic Sign_Op2 = 1'b0;
    logic Div_Zero = 1'b0;
    logic Trial_Cout = 1'b0;
`ifdef DIVCTRL_OVERFLOW_EN
    logic Dividend_Is_Min = 1'b0;
    logic Divisor_Is_Minus1 = 1'b0;
`endif
    logic LOAD_DIVL, LOAD_DIVH, LOAD_ACC, STORE_ACC;
    logic INV_OP1, INV_OP2, INV_RESULT, INV_REM;
    logic OP1_INV_Cin, OP2_INV_Cin, RESULT_INV_Cin, ACC_INV_Cin;
    logic ACC_Cin, RESULT_nP_0, STORE_QUOT, STORE_REM, Busy, Done, Error;
    logic [18:0] all_outs;

    divider_control #(.WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed_Mode(Signed_Mode),
        .Sign_Op1(Sign_Op1), .Sign_Op2(Sign_Op2), .Div_Zero(Div_Zero), .Trial_Cout(Trial_Cout),
`ifdef DIVCTRL_OVERFLOW_EN
        .Dividend_Is_Min(Dividend_Is_Min), .Divisor_Is_Minus1(Divisor_Is_Minus1),
`endif
        .LOAD_DIVL(LOAD_DIVL), .LOAD_DIVH(LOAD_DIVH), .LOAD_ACC(LOAD_ACC), .STORE_ACC(STORE_ACC),
        .INV_OP1(INV_OP1), .INV_OP2(INV_OP2), .INV_RESULT(INV_RESULT), .INV_REM(INV_REM),
        .OP1_INV_Cin(OP1_INV_Cin), .OP2_INV_Cin(OP2_INV_Cin), .RESULT_INV_Cin(RESULT_INV_Cin),
        .ACC_INV_Cin(ACC_INV_Cin), .ACC_Cin(ACC_Cin), .RESULT_nP_0(RESULT_nP_0),
        .STORE_QUOT(STORE_QUOT), .STORE_REM(STORE_REM), .Busy(Busy), .Done(Done), .Error(Error)
    );

    assign all_outs = {LOAD_DIVL, LOAD_DIVH, LOAD_ACC, STORE_ACC, INV_OP1, INV_OP2, INV_RESULT,
                       INV_REM, OP1_INV_Cin, OP2_INV_Cin, RESULT_INV_Cin, ACC_INV_Cin, ACC_Cin,
                       RESULT_nP_0, STORE_QUOT, STORE_REM, Busy, Done, Error};

    always #5 Clock = ~Clock;

    typedef struct {
        int         done_edge;
        logic       err;
        int         stores;
        int         commits;
        logic [7:0] rnp;
        logic [3:0] load_inv;
        logic [3:0] store_inv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] qpat = 8'h00;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: accumulates what the DUT did during one operation and compares at Done.
    // It also plays the array's top-slice carry from qpat, MSB first.
    logic [7:0] rnp_acc;
    logic [3:0] load_inv_c, store_inv_c;
    int commits_n, quot_n, rem_n, idx;
    logic prev_trial;

    task automatic clear_acc();
        rnp_acc = 8'h00; load_inv_c = 4'h0; store_inv_c = 4'h0;
        commits_n = 0; quot_n = 0; rem_n = 0; idx = 7; prev_trial = 1'b0;
    endtask

    initial clear_acc();

    always @(negedge Clock) begin
        if (Reset) begin
            clear_acc();
        end else begin
            if (prev_trial) begin
                rnp_acc = {rnp_acc[6:0], RESULT_nP_0};
                commits_n++;
            end
            prev_trial = ACC_Cin;
            if (LOAD_DIVL) begin
                load_inv_c = {INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin};
                idx = 7;
            end
            if (ACC_Cin && idx >= 0) begin
                Trial_Cout = qpat[idx];
                idx--;
            end
            if (STORE_QUOT) begin
                quot_n++;
                store_inv_c = {INV_RESULT, RESULT_INV_Cin, INV_REM, ACC_INV_Cin};
            end
            if (STORE_REM) rem_n++;
            if (Done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at edge %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_edge", cyc, mon_e.done_edge);
                    check("error", int'(Error), int'(mon_e.err));
                    check("busy_at_done", int'(Busy), 0);
                    check("store_quot_n", quot_n, mon_e.stores);
                    check("store_rem_n", rem_n, mon_e.stores);
                    check("commits", commits_n, mon_e.commits);
                    check("result_np_pattern", int'(rnp_acc), int'(mon_e.rnp));
                    check("load_inv", int'(load_inv_c), int'(mon_e.load_inv));
                    check("store_inv", int'(store_inv_c), int'(mon_e.store_inv));
                end
                clear_acc();
            end
        end
    end

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=Done within %0d cycles", budget);
        end
    endtask

    task automatic run_op(input logic sm, input logic s1, input logic s2, input logic dz,
                          input logic [7:0] qp, input logic [7:0] rnp, input logic err,
                          input int lat, input int commits, input int stores,
                          input logic [3:0] li, input logic [3:0] si);
        exp_t e;
        @(negedge Clock);
        Signed_Mode = sm; Sign_Op1 = s1; Sign_Op2 = s2; Div_Zero = dz; qpat = qp;
        Start = 1'b1;
        e.done_edge = cyc + 1 + lat;
        e.err = err; e.stores = stores; e.commits = commits; e.rnp = rnp;
        e.load_inv = li; e.store_inv = si;
        sb.push_back(e);
        @(negedge Clock);
        Start = 1'b0;
        wait_done(40);
        @(negedge Clock);
    endtask

    initial begin
        int s;
        int n;
        repeat (2) @(negedge Clock);
        check("reset_state_outs", int'(all_outs), 0);
        Reset = 1'b0;

        // 100/7 unsigned, quotient 00001110
        run_op(0, 0, 0, 0, 8'b00001110, 8'b11110001, 0, 18, 8, 1, 4'b0000, 4'b0000);
        // 200/3 unsigned with dividend MSB set: no negation, quotient 01000010
        run_op(0, 1, 0, 0, 8'b01000010, 8'b10111101, 0, 18, 8, 1, 4'b0000, 4'b0000);
        // -100/7 signed
        run_op(1, 1, 0, 0, 8'b00001110, 8'b11110001, 0, 18, 8, 1, 4'b1100, 4'b1111);
        // -100/-7 signed
        run_op(1, 1, 1, 0, 8'b00001110, 8'b11110001, 0, 18, 8, 1, 4'b1111, 4'b0011);
        // 100/-7 signed
        run_op(1, 0, 1, 0, 8'b00001110, 8'b11110001, 0, 18, 8, 1, 4'b0011, 4'b1100);
        // divide by zero
        run_op(0, 0, 0, 1, 8'b00000000, 8'b00000000, 1, 1, 0, 0, 4'b0000, 4'b0000);
        repeat (3) @(negedge Clock);
        check("error_held_idle", int'(Error), 1);
        // 255/1 clears Error
        run_op(0, 0, 0, 0, 8'b11111111, 8'b00000000, 0, 18, 8, 1, 4'b0000, 4'b0000);

        // Abort during TRIAL of iteration 3
        @(negedge Clock);
        qpat = 8'b00001110; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge Clock);
            if (ACC_Cin) n++;
        end
        check("abort_reached_iter3", n, 4);
        #2 Reset = 1'b1;
        #1 check("abort_outs_zero", int'(all_outs), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        run_op(0, 0, 0, 0, 8'b00001110, 8'b11110001, 0, 18, 8, 1, 4'b0000, 4'b0000);

        // Start held high: Done every 20 cycles
        @(negedge Clock);
        Signed_Mode = 1'b0; Sign_Op1 = 1'b0; Sign_Op2 = 1'b0; Div_Zero = 1'b0;
        qpat = 8'b10101010; Start = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.done_edge = s + 18 + 20 * k;
            e.err = 1'b0; e.stores = 1; e.commits = 8; e.rnp = 8'b01010101;
            e.load_inv = 4'b0000; e.store_inv = 4'b0000;
            sb.push_back(e);
        end
        for (int i = 0; i < 80 && cyc < s + 58; i++) @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        check("held_queue_drained", sb.size(), 0);

`ifdef DIVCTRL_OVERFLOW_EN
        Dividend_Is_Min = 1'b1; Divisor_Is_Minus1 = 1'b1;
        run_op(1, 1, 1, 0, 8'b00000000, 8'b00000000, 1, 1, 0, 0, 4'b1111, 4'b0000);
        Dividend_Is_Min = 1'b0; Divisor_Is_Minus1 = 1'b0;
`endif

        repeat (25) @(negedge Clock);
        check("final_queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
